gauss_tap_window: RTL and testbench

- Upstream stage of the Gaussian-blur adder tree.
- Takes a raster-order pixel stream and keeps a horizontal ArrL-tap sliding window per row, with border replication at both row ends.
- Multiplies each tap by its fixed kernel coefficient and presents the ArrL products as one flat vector.
- That vector is exactly the DIn of the adder tree: lane width data_depth, lane k at bits [k*data_depth +: data_depth].

---
 rtl/gauss_tap_window.sv | 98 +++++++++
 tb/tb_gauss_tap_window.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_tap_window.sv
// Horizontal tap window with border replication feeding the Gaussian adder tree.
// Emits ArrL coefficient products per pixel centre as one flat vector.
module gauss_tap_window #(
    parameter int                     pix_w      = 8,
    parameter int                     coef_w     = 8,
    parameter int                     ArrL       = 5,
    parameter int                     img_w      = 640,
    parameter logic [ArrL*coef_w-1:0] COEF       = {8'd16, 8'd64, 8'd96, 8'd64, 8'd16},
    parameter int                     data_depth = pix_w + coef_w
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [pix_w-1:0]           in_pix,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [ArrL*data_depth-1:0] DOut,
    output logic                       out_sol,
    output logic                       out_eol
);
    localparam int HALF = (ArrL - 1) / 2;
    localparam int CW   = (img_w > 1) ? $clog2(img_w) : 1;
    localparam logic [CW-1:0] LAST_COL  = CW'(img_w - 1);
    localparam logic [CW-1:0] FILL_LAST = CW'((HALF > 0) ? HALF - 1 : 0);

    typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;
    // With a single tap there is nothing to pre-fill or drain.
    localparam state_t ROW_START = (HALF == 0) ? S_RUN : S_FILL;

    state_t            r_state;
    logic [CW-1:0]     r_in_col;
    logic [CW-1:0]     r_out_col;
    logic [pix_w-1:0]  r_win [ArrL];
    logic              r_s1_valid;
    logic              r_s1_sol;
    logic              r_s1_eol;

    logic w_accept;
    logic w_flush;
    logic w_produce;

    assign in_ready  = en && (r_state != S_FLUSH);
    assign w_accept  = in_valid && in_ready;
    assign w_flush   = en && (r_state == S_FLUSH);
    assign w_produce = (w_accept && (r_state == S_RUN)) || w_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ROW_START;
            r_in_col   <= '0;
            r_out_col  <= '0;
            for (int i = 0; i < ArrL; i++) r_win[i] <= '0;
            r_s1_valid <= 1'b0;
            r_s1_sol   <= 1'b0;
            r_s1_eol   <= 1'b0;
            out_valid  <= 1'b0;
            out_sol    <= 1'b0;
            out_eol    <= 1'b0;
            DOut       <= '0;
        end else if (en) begin
            r_s1_valid <= w_produce;
            if (w_produce) begin
                r_s1_sol  <= (r_out_col == '0);
                r_s1_eol  <= (r_out_col == LAST_COL);
                r_out_col <= (r_out_col == LAST_COL) ? '0 : r_out_col + CW'(1);
            end

            if (w_accept) begin
                // Column 0 floods the whole window so the left border replicates.
                if (r_in_col == '0) begin
                    for (int i = 0; i < ArrL; i++) r_win[i] <= in_pix;
                end else begin
                    for (int i = 0; i < ArrL - 1; i++) r_win[i] <= r_win[i+1];
                    r_win[ArrL-1] <= in_pix;
                end
                r_in_col <= (r_in_col == LAST_COL) ? '0 : r_in_col + CW'(1);
                if (r_state == S_FILL && r_in_col == FILL_LAST)
                    r_state <= S_RUN;
                else if (r_state == S_RUN && r_in_col == LAST_COL)
                    r_state <= (HALF == 0) ? S_RUN : S_FLUSH;
            end else if (w_flush) begin
                // Newest tap keeps the last pixel: right border replication.
                for (int i = 0; i < ArrL - 1; i++) r_win[i] <= r_win[i+1];
                if (r_out_col == LAST_COL) r_state <= ROW_START;
            end

            out_valid <= r_s1_valid;
            out_sol   <= r_s1_valid && r_s1_sol;
            out_eol   <= r_s1_valid && r_s1_eol;
            if (r_s1_valid) begin
                for (int k = 0; k < ArrL; k++)
                    DOut[k*data_depth +: data_depth] <=
                        data_depth'(r_win[k]) * data_depth'(COEF[k*coef_w +: coef_w]);
            end
        end
    end
endmodule

// File: tb/tb_gauss_tap_window.sv
// Scoreboard bench for gauss_tap_window: two 5-tap instances (unit and default
// coefficients) share one stream, a 1-tap instance runs its own stream.
module tb_gauss_tap_window;
    localparam logic [39:0] ONES = {5{8'd1}};
    localparam logic [39:0] DEFC = {8'd16, 8'd64, 8'd96, 8'd64, 8'd16};

    typedef struct {
        logic [79:0] d;
        logic        sol;
        logic        eol;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en, in_valid, c_valid;
    logic [7:0] in_pix, c_pix;
    logic a_in_ready, a_out_valid, a_sol, a_eol;
    logic b_in_ready, b_out_valid, b_sol, b_eol;
    logic c_in_ready, c_out_valid, c_sol, c_eol;
    logic [79:0] a_dout, b_dout;
    logic [15:0] c_dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a_first_cyc = -1;
    int c_first_cyc = -1;
    bit en_prev = 1'b0;
    exp_t qa[$], qb[$], qc[$];
    exp_t ma, mb, mc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gauss_tap_window #(.pix_w(8), .coef_w(8), .ArrL(5), .img_w(8), .COEF(ONES)) u_a (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_pix(in_pix),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .DOut(a_dout),
        .out_sol(a_sol), .out_eol(a_eol));

    gauss_tap_window #(.pix_w(8), .coef_w(8), .ArrL(5), .img_w(8)) u_b (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_pix(in_pix),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .DOut(b_dout),
        .out_sol(b_sol), .out_eol(b_eol));

    gauss_tap_window #(.pix_w(8), .coef_w(8), .ArrL(1), .img_w(4), .COEF(8'd3)) u_c (
        .clk(clk), .rst(rst), .en(en), .in_valid(c_valid), .in_pix(c_pix),
        .in_ready(c_in_ready), .out_valid(c_out_valid), .DOut(c_dout),
        .out_sol(c_sol), .out_eol(c_eol));

    // A window is new only if en was high on the edge that produced it.
    always @(negedge clk) begin
        if (en_prev && a_out_valid) begin
            if (a_first_cyc < 0) a_first_cyc = cyc;
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected got=%h", a_dout);
            end else begin
                ma = qa.pop_front();
                if ({a_dout, a_sol, a_eol} !== {ma.d, ma.sol, ma.eol}) begin
                    errors++;
                    $display("FAIL a_window got=%h sol=%b eol=%b exp=%h sol=%b eol=%b",
                             a_dout, a_sol, a_eol, ma.d, ma.sol, ma.eol);
                end
            end
        end
        if (en_prev && b_out_valid) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected got=%h", b_dout);
            end else begin
                mb = qb.pop_front();
                if ({b_dout, b_sol, b_eol} !== {mb.d, mb.sol, mb.eol}) begin
                    errors++;
                    $display("FAIL b_window got=%h sol=%b eol=%b exp=%h sol=%b eol=%b",
                             b_dout, b_sol, b_eol, mb.d, mb.sol, mb.eol);
                end
            end
        end
        if (en_prev && c_out_valid) begin
            if (c_first_cyc < 0) c_first_cyc = cyc;
            checks++;
            if (qc.size() == 0) begin
                errors++;
                $display("FAIL c_unexpected got=%h", c_dout);
            end else begin
                mc = qc.pop_front();
                if ({64'd0, c_dout, c_sol, c_eol} !== {mc.d, mc.sol, mc.eol}) begin
                    errors++;
                    $display("FAIL c_window got=%h sol=%b eol=%b exp=%h sol=%b eol=%b",
                             c_dout, c_sol, c_eol, mc.d[15:0], mc.sol, mc.eol);
                end
            end
        end
        en_prev = en;
    end

    function automatic void push_row(input int p[8]);
        logic [39:0] dc;
        dc = DEFC;
        for (int x = 0; x < 8; x++) begin
            exp_t ea, eb;
            ea.d = '0;
            eb.d = '0;
            for (int k = 0; k < 5; k++) begin
                int idx;
                idx = x - 2 + k;
                if (idx < 0) idx = 0;
                if (idx > 7) idx = 7;
                ea.d[k*16 +: 16] = 16'(p[idx]);
                eb.d[k*16 +: 16] = 16'(p[idx]) * 16'(dc[k*8 +: 8]);
            end
            ea.sol = (x == 0);
            ea.eol = (x == 7);
            eb.sol = ea.sol;
            eb.eol = ea.eol;
            qa.push_back(ea);
            qb.push_back(eb);
        end
    endfunction

    task automatic send_a(input logic [7:0] p, output int acc, output int lows);
        bit rdy;
        int n;
        in_valid = 1'b1;
        in_pix = p;
        rdy = 1'b0;
        n = 0;
        lows = 0;
        acc = -1;
        while (!rdy && n < 40) begin
            @(negedge clk);
            rdy = a_in_ready;
            acc = cyc;
            if (!rdy) lows++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!rdy) begin
            errors++;
            $display("FAIL send_a_timeout pix=%0d", p);
        end
    endtask

    task automatic send_c(input logic [7:0] p, output int acc, output int lows);
        bit rdy;
        int n;
        c_valid = 1'b1;
        c_pix = p;
        rdy = 1'b0;
        n = 0;
        lows = 0;
        acc = -1;
        while (!rdy && n < 40) begin
            @(negedge clk);
            rdy = c_in_ready;
            acc = cyc;
            if (!rdy) lows++;
            @(posedge clk);
            #1;
            n++;
        end
        c_valid = 1'b0;
        if (!rdy) begin
            errors++;
            $display("FAIL send_c_timeout pix=%0d", p);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if ((qa.size() + qb.size() + qc.size()) != 0) begin
            errors++;
            $display("FAIL drain left a=%0d b=%0d c=%0d required 0",
                     qa.size(), qb.size(), qc.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        in_valid = 1'b0;
        in_pix = '0;
        c_valid = 1'b0;
        c_pix = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_out_valid, a_sol, a_eol, b_out_valid, c_out_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b required 00000",
                     {a_out_valid, a_sol, a_eol, b_out_valid, c_out_valid});
        end
        checks++;
        if (a_dout !== 80'd0 || b_dout !== 80'd0 || c_dout !== 16'd0) begin
            errors++;
            $display("FAIL reset_dout got a=%h b=%h c=%h required 0", a_dout, b_dout, c_dout);
        end
        checks++;
        if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready got=%b required 111", {a_in_ready, b_in_ready, c_in_ready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int p[8];
        int acc, lows, acc12, lowc, n;
        acc12 = -100;
        for (int i = 0; i < 8; i++) p[i] = 10 + i;
        push_row(p);
        a_first_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            send_a(8'(p[i]), acc, lows);
            if (i == 2) acc12 = acc;
        end
        lowc = 0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (!a_in_ready) lowc++;
            else break;
        end
        @(posedge clk);
        #1;
        checks++;
        if (lowc != 2) begin
            errors++;
            $display("FAIL flush_ready_low got=%0d required 2", lowc);
        end
        drain();
        checks++;
        if (a_first_cyc - acc12 != 2) begin
            errors++;
            $display("FAIL first_latency got=%0d required 2", a_first_cyc - acc12);
        end
    endtask

    task automatic test_all_255();
        int p[8];
        int acc, lows, n;
        for (int i = 0; i < 8; i++) p[i] = 255;
        push_row(p);
        for (int i = 0; i < 8; i++) send_a(8'(p[i]), acc, lows);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_out_valid && n < 10);
        checks++;
        if (b_dout[79:64] !== 16'd4080) begin
            errors++;
            $display("FAIL lane4_255 got=%0d required 4080", b_dout[79:64]);
        end
        checks++;
        if (b_dout !== {16'd4080, 16'd16320, 16'd24480, 16'd16320, 16'd4080}) begin
            errors++;
            $display("FAIL window_255 got=%h", b_dout);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_gaps();
        int p[8];
        int acc, lows;
        for (int i = 0; i < 8; i++) p[i] = 10 + i;
        push_row(p);
        for (int i = 0; i < 8; i++) begin
            send_a(8'(p[i]), acc, lows);
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_en_freeze();
        int p[8];
        int acc, lows;
        logic [79:0] d0;
        logic [2:0] f0;
        for (int i = 0; i < 8; i++) p[i] = 10 + i;
        push_row(p);
        for (int seg = 0; seg < 2; seg++) begin
            for (int i = seg * 4; i < seg * 4 + 4; i++) send_a(8'(p[i]), acc, lows);
            en = 1'b0;
            @(negedge clk);
            d0 = a_dout;
            f0 = {a_out_valid, a_sol, a_eol};
            checks++;
            if (a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL freeze_ready seg=%0d got=%b required 0", seg, a_in_ready);
            end
            repeat (2) begin
                @(negedge clk);
                checks++;
                if (a_dout !== d0 || {a_out_valid, a_sol, a_eol} !== f0 || a_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL freeze_hold seg=%0d got=%h/%b/%b required %h/%b/0",
                             seg, a_dout, {a_out_valid, a_sol, a_eol}, a_in_ready, d0, f0);
                end
            end
            @(posedge clk);
            #1;
            en = 1'b1;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int p[8];
        int acc, lows;
        for (int i = 0; i < 4; i++) send_a(8'(10 + i), acc, lows);
        rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_valid got a=%b b=%b required 0", a_out_valid, b_out_valid);
        end
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) p[i] = 20 + i;
        push_row(p);
        for (int i = 0; i < 8; i++) send_a(8'(p[i]), acc, lows);
        drain();
    endtask

    task automatic test_arrl1();
        int acc, lows, lows_tot, acc1;
        exp_t e;
        acc1 = -100;
        lows_tot = 0;
        for (int x = 0; x < 4; x++) begin
            e.d = 80'(3 * (x + 1));
            e.sol = (x == 0);
            e.eol = (x == 3);
            qc.push_back(e);
        end
        c_first_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            send_c(8'(i + 1), acc, lows);
            lows_tot += lows;
            if (i == 0) acc1 = acc;
        end
        drain();
        checks++;
        if (lows_tot != 0) begin
            errors++;
            $display("FAIL arrl1_ready_low got=%0d required 0", lows_tot);
        end
        checks++;
        if (c_first_cyc - acc1 != 2) begin
            errors++;
            $display("FAIL arrl1_latency got=%0d required 2", c_first_cyc - acc1);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_all_255();
        test_gaps();
        test_en_freeze();
        test_reset_mid();
        test_arrl1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
